// File: rtl/axi4lite_reg_slave.sv
// axi4lite_reg_slave: AXI4-Lite slave exposing four 32-bit registers; REG0 drives SIG_OUT.
// Revision: 1.0
`default_nettype none

module axi4lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   SIG_OUT
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] W_IDLE      = 2'd0;
  localparam logic [1:0] W_WAIT_DATA = 2'd1;
  localparam logic [1:0] W_WAIT_ADDR = 2'd2;
  localparam logic [1:0] W_RESP      = 2'd3;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [1:0]                    wstate_q, wstate_d;
  logic [1:0]                    awaddr_q, awaddr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]             wstrb_q, wstrb_d;
  logic                          bvalid_q, bvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [4];
  logic [0:0]                    rstate_q, rstate_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_wr_en;
  logic [1:0]                    w_wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]             w_wr_strb;
  logic                          w_unused;

  assign S_AXI_AWREADY = (wstate_q == W_IDLE) || (wstate_q == W_WAIT_ADDR);
  assign S_AXI_WREADY  = (wstate_q == W_IDLE) || (wstate_q == W_WAIT_DATA);
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = (rstate_q == R_IDLE);
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign SIG_OUT       = regs_q[0];

  assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  // Byte offset bits and protection attributes carry no meaning for this register file.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    wstate_d  = wstate_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    w_wr_en   = 1'b0;
    w_wr_idx  = awaddr_q;
    w_wr_data = wdata_q;
    w_wr_strb = wstrb_q;
    case (wstate_q)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wr_en   = 1'b1;
          w_wr_idx  = S_AXI_AWADDR[3:2];
          w_wr_data = S_AXI_WDATA;
          w_wr_strb = S_AXI_WSTRB;
          bvalid_d  = 1'b1;
          wstate_d  = W_RESP;
        end else if (w_aw_hs) begin
          awaddr_d = S_AXI_AWADDR[3:2];
          wstate_d = W_WAIT_DATA;
        end else if (w_w_hs) begin
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
          wstate_d = W_WAIT_ADDR;
        end
      end
      W_WAIT_DATA: begin
        if (w_w_hs) begin
          w_wr_en   = 1'b1;
          w_wr_data = S_AXI_WDATA;
          w_wr_strb = S_AXI_WSTRB;
          bvalid_d  = 1'b1;
          wstate_d  = W_RESP;
        end
      end
      W_WAIT_ADDR: begin
        if (w_aw_hs) begin
          w_wr_en  = 1'b1;
          w_wr_idx = S_AXI_AWADDR[3:2];
          bvalid_d = 1'b1;
          wstate_d = W_RESP;
        end
      end
      default: begin
        if (S_AXI_BREADY) begin
          bvalid_d = 1'b0;
          wstate_d = W_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
    if (w_wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_wr_strb[b]) regs_d[w_wr_idx][8*b +: 8] = w_wr_data[8*b +: 8];
      end
    end
  end

  // Reads sample the pre-write register contents, so a colliding write is not visible yet.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        if (S_AXI_ARVALID) begin
          rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
          rstate_d = R_DATA;
        end
      end
      default: begin
        if (S_AXI_RREADY) rstate_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      wstate_q <= wstate_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi4lite_reg_slave.sv
// tb_axi4lite_reg_slave: vector table plus read scoreboard for axi4lite_reg_slave.
// Revision: 1.0
`default_nettype none

module tb_axi4lite_reg_slave;

  logic        clk;
  logic        rst;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] sig_out;

  int total = 0;
  int bad   = 0;
  int n_wr  = 0;
  int b_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  axi4lite_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .ACLK(clk),
    .ARESET(rst),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .SIG_OUT(sig_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return awready;
      1:       return wready;
      2:       return arready;
      3:       return bvalid && bready;
      4:       return rvalid && rready;
      5:       return bvalid;
      default: return rvalid;
    endcase
  endfunction

  // Returns at the negedge where the condition holds; a missed bound is a failed comparison.
  task automatic wait_for(input int which, input string nm);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (sig(which)) return;
    end
    total++;
    bad++;
    $display("FAIL timeout_%s: got no event, expected one within 60 cycles", nm);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    n_wr++;
    @(posedge clk); #1;
    fork
      begin
        repeat (aw_dly) begin @(posedge clk); #1; end
        awaddr  = a;
        awvalid = 1'b1;
        wait_for(0, "awready");
        @(posedge clk); #1;
        awvalid = 1'b0;
      end
      begin
        repeat (w_dly) begin @(posedge clk); #1; end
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        wait_for(1, "wready");
        @(posedge clk); #1;
        wvalid = 1'b0;
      end
    join
    wait_for(3, "bhandshake");
    check("bresp", {30'd0, bresp}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    araddr  = a;
    arvalid = 1'b1;
    wait_for(2, "arready");
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_for(4, "rhandshake");
    @(posedge clk); #1;
  endtask

  // Scoreboard side: every completed read is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rvalid && rready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdata_unexpected: got %h, expected no read response", rdata);
      end else begin
        check("rdata", rdata, exp_q.pop_front());
        check("rresp", {30'd0, rresp}, 32'h0);
      end
    end
    if (!rst && bvalid && bready) b_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 ns");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
    vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
    vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
    vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004};
    vecs[4] = '{4'h4, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF};
    vecs[5] = '{4'h4, 32'h1234_5678, 4'h5, 32'hFF34_FF78};
    vecs[6] = '{4'h9, 32'hA5A5_A5A5, 4'h8, 32'hA500_0003};
    vecs[7] = '{4'hC, 32'hCAFE_F00D, 4'h0, 32'h0000_0004};
    vecs[8] = '{4'h2, 32'h1122_3344, 4'h3, 32'h0000_3344};

    rst = 1'b1;
    awaddr = '0; awprot = 3'b010; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = 3'b101; arvalid = 1'b0; rready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bvalid", {31'd0, bvalid}, 32'h0);
    check("rst_rvalid", {31'd0, rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_sig_out", sig_out, 32'h0);
    check("rst_readies", {29'd0, awready, wready, arready}, 32'h7);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0);
      axi_read(vecs[i].addr, vecs[i].exp);
    end
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'(i + 1));
    @(negedge clk);
    check("sig_out_reg0", sig_out, 32'h0000_0001);
    for (int i = 4; i < 9; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0);
      axi_read(vecs[i].addr, vecs[i].exp);
    end
    @(negedge clk);
    check("sig_out_strb", sig_out, 32'h0000_3344);

    // Address leads data by three cycles, then data leads address.
    fork
      axi_write(4'h8, 32'hDEAD_BEEF, 4'hF, 0, 3);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("wait_data_readies", {30'd0, awready, wready}, 32'h1);
      end
    join
    fork
      axi_write(4'hC, 32'h600D_CAFE, 4'hF, 3, 0);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("wait_addr_readies", {30'd0, awready, wready}, 32'h2);
      end
    join
    axi_read(4'h8, 32'hDEAD_BEEF);
    axi_read(4'hC, 32'h600D_CAFE);

    // Read and write to REG0 accepted on the same edge.
    axi_write(4'h0, 32'h0000_0001, 4'hF, 0, 0);
    fork
      axi_read(4'h0, 32'h0000_0001);
      axi_write(4'h0, 32'h0000_000A, 4'hF, 0, 0);
    join
    axi_read(4'h0, 32'h0000_000A);
    @(negedge clk);
    check("sig_out_new", sig_out, 32'h0000_000A);

    // Write response held off by the master.
    bready = 1'b0;
    fork
      axi_write(4'h4, 32'h0000_0077, 4'hF, 0, 0);
      begin
        wait_for(5, "bvalid");
        repeat (5) begin
          @(negedge clk);
          check("bstall", {29'd0, bvalid, awready, wready}, 32'h4);
        end
        @(posedge clk); #1;
        bready = 1'b1;
      end
    join

    // Read response held off by the master.
    rready = 1'b0;
    fork
      axi_read(4'h4, 32'h0000_0077);
      begin
        wait_for(6, "rvalid");
        repeat (5) begin
          @(negedge clk);
          check("rstall_ctl", {30'd0, rvalid, arready}, 32'h2);
          check("rstall_data", rdata, 32'h0000_0077);
        end
        @(posedge clk); #1;
        rready = 1'b1;
      end
    join

    check("b_count", b_cnt, n_wr);

    // Reset while a write response is pending: no response, registers cleared.
    @(posedge clk); #1;
    bready = 1'b0;
    awaddr = 4'h8; awvalid = 1'b1;
    wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_bvalid", {31'd0, bvalid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_bvalid", {31'd0, bvalid}, 32'h0);
    check("async_rst_sig_out", sig_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bready = 1'b1;
    #1;
    check("post_rst_readies", {29'd0, awready, wready, arready}, 32'h7);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'h0);
    check("b_count_after_rst", b_cnt, n_wr);
    check("sb_empty", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
